// File: rtl/ps2_kbd_wb_if.sv
// Wishbone slave bus bundle for the PS/2 keyboard receiver.
// The master drives address/data/strobes; the slave returns read data and acknowledge.
interface ps2_kbd_wb_if;
    logic [15:0] wb_adr_i;
    logic [15:0] wb_dat_i;
    logic [15:0] wb_dat_o;
    logic        wb_cyc_i;
    logic        wb_we_i;
    logic        wb_stb_i;
    logic        wb_ack_o;
    logic [1:0]  wb_sel_i;

    modport master (
        output wb_adr_i, wb_dat_i, wb_cyc_i, wb_we_i, wb_stb_i, wb_sel_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_cyc_i, wb_we_i, wb_stb_i, wb_sel_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/ps2_kbd_wb.sv
// PS/2 keyboard receiver with scancode FIFO, CSR/DATA registers on Wishbone
// and a level-qualified edge-set interrupt request.
module ps2_kbd_wb #(
    parameter int FIFO_AW    = 3,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_i,
    ps2_kbd_wb_if.slave    wb,
    output logic           irq,
    input  logic           iack,
    input  logic           ps2_clk,
    input  logic           ps2_data
);
    localparam int FW    = $clog2(FILTER_LEN + 1);
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;

    function automatic logic frame_ok(input logic [7:0] data, input logic par, input logic stop);
        return stop & (^{data, par});
    endfunction

    logic [1:0]         clk_sync_r, dat_sync_r;
    logic               filt_clk_r;
    logic [FW-1:0]      filt_cnt_r;
    logic               strobe_s, bit_s;
    state_t             state_r, next_state_s;
    logic [2:0]         bit_cnt_r;
    logic [7:0]         shift_r;
    logic               par_r;
    logic [TW-1:0]      tmo_r;
    logic               timeout_s, push_s, frame_err_s;
    logic [7:0]         mem_r [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [FIFO_AW:0]   count_r;
    logic               empty_s, full_s, push_ok_s, ovf_set_s, pop_s;
    logic               acc_s, rd_s, wr_s, csr_wr_s, is_data_s;
    logic               ie_r, err_r, ovf_r, ack_r, req_s, req_q_r, irq_r;
    logic [15:0]        dat_o_r, csr_s, rd_data_s;
    logic               unused_s;

    assign unused_s = ^{wb.wb_adr_i[15:2], wb.wb_adr_i[0], wb.wb_dat_i[13:7], wb.wb_dat_i[5:0]};

    // Synchronisers and glitch filter: the filtered clock flips after FILTER_LEN differing samples.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            clk_sync_r <= 2'b11;
            dat_sync_r <= 2'b11;
            filt_clk_r <= 1'b1;
            filt_cnt_r <= '0;
        end else begin
            clk_sync_r <= {clk_sync_r[0], ps2_clk};
            dat_sync_r <= {dat_sync_r[0], ps2_data};
            if (clk_sync_r[1] == filt_clk_r) begin
                filt_cnt_r <= '0;
            end else if (filt_cnt_r == FW'(FILTER_LEN - 1)) begin
                filt_clk_r <= clk_sync_r[1];
                filt_cnt_r <= '0;
            end else begin
                filt_cnt_r <= filt_cnt_r + 1'b1;
            end
        end
    end

    assign strobe_s  = filt_clk_r & ~clk_sync_r[1] & (filt_cnt_r == FW'(FILTER_LEN - 1));
    assign bit_s     = dat_sync_r[1];
    assign timeout_s = (tmo_r == TW'(TIMEOUT));

    // Receiver next-state and frame-completion decode.
    always_comb begin
        next_state_s = state_r;
        push_s       = 1'b0;
        frame_err_s  = 1'b0;
        if ((state_r != ST_IDLE) && timeout_s) begin
            next_state_s = ST_IDLE;
        end else if (strobe_s) begin
            case (state_r)
                ST_IDLE:   next_state_s = bit_s ? ST_IDLE : ST_DATA;
                ST_DATA:   next_state_s = (bit_cnt_r == 3'd7) ? ST_PARITY : ST_DATA;
                ST_PARITY: next_state_s = ST_STOP;
                ST_STOP: begin
                    next_state_s = ST_IDLE;
                    if (frame_ok(shift_r, par_r, bit_s)) begin
                        push_s = 1'b1;
                    end else begin
                        frame_err_s = 1'b1;
                    end
                end
                default:   next_state_s = ST_IDLE;
            endcase
        end else begin
            next_state_s = state_r;
        end
    end

    // Receiver state, shift register and inactivity timer.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
            par_r     <= 1'b0;
            tmo_r     <= '0;
        end else begin
            state_r <= next_state_s;
            if (strobe_s) begin
                case (state_r)
                    ST_IDLE:   bit_cnt_r <= 3'd0;
                    ST_DATA: begin
                        shift_r   <= {bit_s, shift_r[7:1]};
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                    end
                    ST_PARITY: par_r <= bit_s;
                    default:   bit_cnt_r <= bit_cnt_r;
                endcase
            end
            if (strobe_s || (state_r == ST_IDLE)) begin
                tmo_r <= '0;
            end else if (!timeout_s) begin
                tmo_r <= tmo_r + 1'b1;
            end
        end
    end

    assign acc_s     = wb.wb_cyc_i & wb.wb_stb_i & ~ack_r;
    assign rd_s      = acc_s & ~wb.wb_we_i;
    assign wr_s      = acc_s & wb.wb_we_i;
    assign is_data_s = wb.wb_adr_i[1];
    assign csr_wr_s  = wr_s & ~is_data_s;
    assign empty_s   = (count_r == '0);
    assign full_s    = (count_r == (FIFO_AW + 1)'(DEPTH));
    assign pop_s     = rd_s & is_data_s & ~empty_s;
    assign push_ok_s = push_s & (~full_s | pop_s);
    assign ovf_set_s = push_s & full_s & ~pop_s;

    // FIFO storage; entries are only meaningful while counted.
    always_ff @(posedge wb_clk_i) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= shift_r;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + 1'b1;
            if (pop_s)     rd_ptr_r <= rd_ptr_r + 1'b1;
            case ({push_ok_s, pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign csr_s = {err_r, ovf_r, 6'b000000, ~empty_s, ie_r, 6'b000000};

    // Read mux for the acknowledged cycle.
    always_comb begin
        rd_data_s = 16'h0000;
        if (!rd_s) begin
            rd_data_s = 16'h0000;
        end else if (is_data_s) begin
            rd_data_s = empty_s ? 16'h0000 : {8'h00, mem_r[rd_ptr_r]};
        end else begin
            rd_data_s = csr_s;
        end
    end

    // Control/status flags; a new error or overflow outranks a simultaneous clear.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ie_r  <= 1'b0;
            err_r <= 1'b0;
            ovf_r <= 1'b0;
        end else begin
            if (csr_wr_s && wb.wb_sel_i[0]) ie_r <= wb.wb_dat_i[6];
            if (frame_err_s) begin
                err_r <= 1'b1;
            end else if (csr_wr_s && wb.wb_sel_i[1] && wb.wb_dat_i[15]) begin
                err_r <= 1'b0;
            end
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end else if (csr_wr_s && wb.wb_sel_i[1] && wb.wb_dat_i[14]) begin
                ovf_r <= 1'b0;
            end
        end
    end

    // Single-cycle acknowledge with registered read data.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_r   <= 1'b0;
            dat_o_r <= 16'h0000;
        end else begin
            ack_r   <= acc_s;
            dat_o_r <= rd_data_s;
        end
    end

    assign req_s = ie_r & ~empty_s;

    // Interrupt: set on a rising request, dropped by iack or by the request going away.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            req_q_r <= 1'b0;
            irq_r   <= 1'b0;
        end else begin
            req_q_r <= req_s;
            if (req_s && !req_q_r) begin
                irq_r <= 1'b1;
            end else if (iack || !req_s) begin
                irq_r <= 1'b0;
            end else begin
                irq_r <= irq_r;
            end
        end
    end

    assign wb.wb_ack_o = ack_r;
    assign wb.wb_dat_o = dat_o_r;
    assign irq         = irq_r;
endmodule

// File: tb/tb_ps2_kbd_wb.sv
// Bench for ps2_kbd_wb: directed scenarios plus random traffic, reads checked
// by an ack-driven monitor against a queue-based model of the keyboard port.
module tb_ps2_kbd_wb;
    localparam int HALF = 25;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic irq;
    logic iack = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;

    ps2_kbd_wb_if bus();

    ps2_kbd_wb dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wb       (bus.slave),
        .irq      (irq),
        .iack     (iack),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data)
    );

    always #10 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] val;
        bit          chk;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] mq[$];
    bit         m_err = 1'b0, m_ovf = 1'b0, m_ie = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [15:0] model_csr();
        return {m_err, m_ovf, 6'b000000, (mq.size() != 0), m_ie, 6'b000000};
    endfunction

    function automatic logic [15:0] model_data_read();
        if (mq.size() == 0) return 16'h0000;
        return {8'h00, mq.pop_front()};
    endfunction

    task automatic model_frame(input logic [7:0] b, input bit bad);
        if (bad) m_err = 1'b1;
        else if (mq.size() < 8) mq.push_back(b);
        else m_ovf = 1'b1;
    endtask

    task automatic model_reset();
        mq.delete();
        m_err = 1'b0;
        m_ovf = 1'b0;
        m_ie  = 1'b0;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.wb_ack_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: ack with no access outstanding, data %h", bus.wb_dat_o);
                end else begin
                    e = exp_q.pop_front();
                    if (e.chk) check(e.name, bus.wb_dat_o, e.val);
                end
            end
        end
    endtask

    task automatic access(input bit we, input bit a1, input logic [15:0] d, input logic [1:0] sel,
                          input string name, input logic [15:0] expv, input bit chk);
        bit got = 1'b0;
        exp_q.push_back('{name, expv, chk});
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = we;
        bus.wb_adr_i = {14'd0, a1, 1'b0};
        bus.wb_dat_i = d;
        bus.wb_sel_i = sel;
        for (int i = 0; i < 8 && !got; i++) begin
            tick(1);
            if (bus.wb_ack_o === 1'b1) got = 1'b1;
        end
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_ack_timeout: no ack within 8 cycles", name);
        end
        tick(1);
    endtask

    task automatic rd_exp(input bit a1, input logic [15:0] expv, input string name);
        logic [15:0] dummy;
        if (a1) dummy = model_data_read();
        access(1'b0, a1, 16'h0000, 2'b11, name, expv, 1'b1);
    endtask

    task automatic rd_model(input bit a1, input string name);
        logic [15:0] e;
        e = a1 ? model_data_read() : model_csr();
        access(1'b0, a1, 16'h0000, 2'b11, name, e, 1'b1);
    endtask

    task automatic wr(input bit a1, input logic [15:0] d, input logic [1:0] sel);
        if (!a1) begin
            if (sel[0]) m_ie = d[6];
            if (sel[1] && d[15]) m_err = 1'b0;
            if (sel[1] && d[14]) m_ovf = 1'b0;
        end
        access(1'b1, a1, d, sel, "write", 16'h0000, 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad, input int nbits, input bit glitch);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            tick(HALF);
            if (glitch && i == 4) begin
                ps2_clk = 1'b0;
                tick(3);
                ps2_clk = 1'b1;
                tick(HALF);
            end
            ps2_clk = 1'b0;
            tick(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        tick(2 * HALF);
        if (nbits == 11) model_frame(b, bad);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  rb;
        logic [15:0] rd;
        int          r;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = 16'h0000;
        bus.wb_dat_i = 16'h0000;
        bus.wb_sel_i = 2'b00;
        fork
            monitor();
        join_none

        tick(5);
        check("reset_irq", {15'd0, irq}, 16'h0000);
        check("reset_ack", {15'd0, bus.wb_ack_o}, 16'h0000);
        check("reset_dat", bus.wb_dat_o, 16'h0000);
        rst = 1'b0;
        tick(2);
        rd_exp(1'b0, 16'h0000, "reset_csr");

        // Single good frame
        send_frame(8'h1C, 1'b0, 11, 1'b0);
        rd_exp(1'b0, 16'o000200, "t1_csr_rdy");
        rd_exp(1'b1, 16'h001C, "t1_data");
        rd_exp(1'b0, 16'o000000, "t1_csr_empty");

        // Parity error, clear only through the high byte lane
        send_frame(8'h1C, 1'b1, 11, 1'b0);
        rd_exp(1'b0, 16'o100000, "t2_csr_err");
        wr(1'b0, 16'o100000, 2'b01);
        rd_exp(1'b0, 16'o100000, "t2_err_kept_lowlane");
        wr(1'b0, 16'o100000, 2'b10);
        rd_exp(1'b0, 16'o000000, "t2_err_cleared");

        // Overflow
        for (int k = 1; k <= 9; k++) send_frame(8'(k), 1'b0, 11, 1'b0);
        rd_exp(1'b0, 16'h4080, "t3_csr_ovf");
        for (int k = 1; k <= 8; k++) rd_exp(1'b1, 16'(k), "t3_data_order");
        rd_exp(1'b1, 16'h0000, "t3_data_empty");
        rd_exp(1'b0, 16'h4000, "t3_csr_rdy0");
        wr(1'b0, 16'h4000, 2'b10);
        rd_exp(1'b0, 16'h0000, "t3_ovf_cleared");

        // Interrupt
        wr(1'b0, 16'o000100, 2'b01);
        check("t4_irq_idle", {15'd0, irq}, 16'h0000);
        send_frame(8'h5A, 1'b0, 11, 1'b0);
        check("t4_irq_set", {15'd0, irq}, 16'h0001);
        iack = 1'b1;
        tick(1);
        iack = 1'b0;
        tick(1);
        check("t4_irq_iack", {15'd0, irq}, 16'h0000);
        tick(5);
        check("t4_irq_no_reassert", {15'd0, irq}, 16'h0000);
        rd_exp(1'b0, 16'h00C0, "t4_csr");
        rd_exp(1'b1, 16'h005A, "t4_data");
        send_frame(8'h3C, 1'b0, 11, 1'b0);
        check("t4_irq_second", {15'd0, irq}, 16'h0001);
        rd_exp(1'b1, 16'h003C, "t4_data2");
        tick(2);
        check("t4_irq_drained", {15'd0, irq}, 16'h0000);
        wr(1'b0, 16'h0000, 2'b01);
        send_frame(8'h11, 1'b0, 11, 1'b0);
        check("t4_irq_ie_off", {15'd0, irq}, 16'h0000);
        wr(1'b0, 16'o000100, 2'b01);
        tick(2);
        check("t4_irq_ie_enable", {15'd0, irq}, 16'h0001);
        rd_exp(1'b1, 16'h0011, "t4_data3");
        wr(1'b0, 16'h0000, 2'b01);
        send_frame(8'h22, 1'b0, 11, 1'b0);
        wr(1'b1, 16'hFFFF, 2'b11);
        rd_exp(1'b0, 16'h0080, "t4_data_write_noop");
        rd_exp(1'b1, 16'h0022, "t4_data4");

        // Partial frame abandoned by the inactivity timer
        send_frame(8'hF0, 1'b0, 5, 1'b0);
        tick(50100);
        send_frame(8'h29, 1'b0, 11, 1'b0);
        rd_exp(1'b0, 16'h0080, "t5_csr");
        rd_exp(1'b1, 16'h0029, "t5_data");

        // Short clock glitches in idle (with data low) and mid-frame
        ps2_data = 1'b0;
        ps2_clk  = 1'b0;
        tick(3);
        ps2_clk  = 1'b1;
        tick(20);
        ps2_data = 1'b1;
        tick(20);
        send_frame(8'h6B, 1'b0, 11, 1'b1);
        rd_exp(1'b0, 16'h0080, "t6_csr");
        rd_exp(1'b1, 16'h006B, "t6_data");

        // Reset mid-frame and during an access
        wr(1'b0, 16'o000100, 2'b01);
        send_frame(8'h12, 1'b0, 11, 1'b0);
        check("t7_irq_before", {15'd0, irq}, 16'h0001);
        send_frame(8'h55, 1'b0, 6, 1'b0);
        rst = 1'b1;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_adr_i = 16'h0002;
        tick(1);
        check("t7_ack_in_reset", {15'd0, bus.wb_ack_o}, 16'h0000);
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        tick(1);
        rst = 1'b0;
        model_reset();
        tick(2);
        check("t7_irq_after", {15'd0, irq}, 16'h0000);
        rd_exp(1'b0, 16'h0000, "t7_csr_after");
        send_frame(8'h45, 1'b0, 11, 1'b0);
        rd_exp(1'b1, 16'h0045, "t7_data_after");

        // Random traffic against the model
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 5);
            case (r)
                0, 1: begin
                    rb = 8'($urandom);
                    send_frame(rb, ($urandom_range(0, 4) == 0), 11, 1'b0);
                end
                2, 5: rd_model(1'b1, "rand_data");
                3:    rd_model(1'b0, "rand_csr");
                default: begin
                    rd = 16'($urandom);
                    wr(1'b0, rd, 2'($urandom_range(0, 3)));
                end
            endcase
            tick(3);
            check("rand_irq", {15'd0, irq}, {15'd0, (m_ie && mq.size() != 0)});
        end
        rd_model(1'b0, "final_csr");

        tick(5);
        check("scoreboard_drained", 16'(exp_q.size()), 16'h0000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
